kf_matvec_sched: RTL

Two-requester scheduler and sequencer for a shared signed NOS×NOS matrix by NOS-vector multiply in the Kalman filter datapath. The predict and update stages both need matrix-vector products. This block arbitrates between them round-robin and latches the winner's operands. It computes the product with a single multiply-accumulate unit, one product per clock, and returns a registered result tagged with the requester ID. It replaces two full-parallel combinational multipliers with one sequenced MAC.

---
 rtl/kf_matvec_sched.sv | 113 +++++++++++
 1 files changed

// File: rtl/kf_matvec_sched.sv
// kf_matvec_sched: round-robin shared sequencer for a signed NOS x NOS matrix by NOS-vector multiply
module kf_matvec_sched #(
    parameter int WIDTH = 16,
    parameter int NOS   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] a0 [0:NOS-1][0:NOS-1],
    input  logic [WIDTH-1:0] a1 [0:NOS-1][0:NOS-1],
    input  logic [WIDTH-1:0] b0 [0:NOS-1],
    input  logic [WIDTH-1:0] b1 [0:NOS-1],
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic             res_id,
    output logic [WIDTH-1:0] res [0:NOS-1]
);
    localparam int IW = (NOS > 1) ? $clog2(NOS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NOS - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic ptr_q, ptr_d, id_q, id_d, res_id_q, res_id_d, win;
    logic [IW-1:0] i_q, i_d, k_q, k_d;
    logic [WIDTH-1:0] acc_q, acc_d, sum;
    logic [WIDTH-1:0] a_q [0:NOS-1][0:NOS-1];
    logic [WIDTH-1:0] a_d [0:NOS-1][0:NOS-1];
    logic [WIDTH-1:0] b_q [0:NOS-1];
    logic [WIDTH-1:0] b_d [0:NOS-1];
    logic [WIDTH-1:0] row_q [0:NOS-1];
    logic [WIDTH-1:0] row_d [0:NOS-1];
    logic [WIDTH-1:0] res_q [0:NOS-1];
    logic [WIDTH-1:0] res_d [0:NOS-1];
    always_comb begin
        win      = (req == 2'b11) ? ptr_q : req[1];
        gnt      = (rst_n && state_q == IDLE && req != 2'b00) ? (win ? 2'b10 : 2'b01) : 2'b00;
        // low WIDTH bits of a two's-complement product do not depend on signedness
        sum      = acc_q + a_q[i_q][k_q] * b_q[k_q];
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        res_id_d = res_id_q;
        i_d      = i_q;
        k_d      = k_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        row_d    = row_q;
        res_d    = res_q;
        if (state_q == IDLE && gnt != 2'b00) begin
            state_d = RUN;
            ptr_d   = ~win;
            id_d    = win;
            acc_d   = '0;
            i_d     = '0;
            k_d     = '0;
            if (win) begin
                a_d = a1;
                b_d = b1;
            end else begin
                a_d = a0;
                b_d = b0;
            end
        end else if (state_q == RUN) begin
            acc_d = sum;
            k_d   = k_q + IW'(1);
            if (k_q == LAST) begin
                row_d[i_q] = sum;
                acc_d      = '0;
                k_d        = '0;
                i_d        = i_q + IW'(1);
                if (i_q == LAST) begin
                    res_d    = row_d;
                    res_id_d = id_q;
                    state_d  = DONE;
                end
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            id_q     <= 1'b0;
            res_id_q <= 1'b0;
            i_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            a_q      <= '{default: '0};
            b_q      <= '{default: '0};
            row_q    <= '{default: '0};
            res_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            res_id_q <= res_id_d;
            i_q      <= i_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            row_q    <= row_d;
            res_q    <= res_d;
        end
    end
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign res_id = res_id_q;
    assign res    = res_q;
endmodule
